// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: streams words from a combinational instruction memory
// to decode over a valid/ready handshake. Define FETCH_HALT_EN to stop fetch on a zero word.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted
);

  // state  | meaning
  // S_WAIT | first cycle after reset, memory settling, no fetch
  // S_RUN  | fetching one word per cycle while decode keeps up
  // S_HALT | stopped on a zero word (FETCH_HALT_EN builds only)
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        load;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    load         = (state_q == S_RUN) && !redirect_valid && (!inst_valid_q || inst_ready);

    if (state_q == S_WAIT) begin
      state_d = S_RUN;
    end else if (redirect_valid) begin
      // Squash wins even over a simultaneous accept of the current word.
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      inst_valid_d = 1'b0;
      state_d      = S_RUN;
    end else if (load) begin
`ifdef FETCH_HALT_EN
      if (mem_dout == 32'h0000_0000) begin
        inst_valid_d = 1'b0;
        state_d      = S_HALT;
      end else
`endif
      begin
        inst_out_d   = mem_dout;
        inst_pc_d    = fetch_pc_q;
        inst_valid_d = 1'b1;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end
    end else if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_WAIT;
      fetch_pc_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign mem_addr   = fetch_pc_q[ADDR_W+1:2];
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
`ifdef FETCH_HALT_EN
  assign halted     = (state_q == S_HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus predicts the delivered pc/word stream,
// a monitor pops and compares on every transfer.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 9;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              inst_ready = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout, inst_out, inst_pc;
  logic              inst_valid, halted;
  logic [31:0]       mem [0:511];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    bit          halt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] nxt_pc;
  bit          stopped;
  int          s_since = 0;
  int          n_pass = 0, n_total = 0, n_xfer = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  assign mem_dout = mem[mem_addr];
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Expected stream: consecutive words from the current start pc, ending at a zero word when halting.
  task automatic top_up();
    logic [31:0] w;
    while (!stopped && exp_q.size() < 8) begin
      w = mem[nxt_pc[ADDR_W+1:2]];
      if (HALT_EN && w == 32'h0) begin
        exp_q.push_back('{pc: nxt_pc, word: w, halt: 1'b1});
        stopped = 1'b1;
      end else begin
        exp_q.push_back('{pc: nxt_pc, word: w, halt: 1'b0});
        nxt_pc = nxt_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = r; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (r) begin
      exp_q.delete(); nxt_pc = RESET_PC; stopped = 1'b0; s_since = 0;
    end else begin
      if (s_since < 100) s_since++;
      if (rv && s_since >= 2) begin
        exp_q.delete(); nxt_pc = {rpc[31:2], 2'b00}; stopped = 1'b0;
      end
    end
    top_up();
  endtask

  // Monitor: samples 2 time units after the stimulus update, well before the next rising edge.
  int          since = 0;
  bit          p_squash = 1'b1, p_stall = 1'b0, squash;
  logic [31:0] p_out, p_pc;
  always begin
    @(negedge clk); #2;
    if (reset) begin
      since = 0; p_squash = 1'b1; p_stall = 1'b0;
    end else begin
      if (since < 100) since++;
      if (p_squash) check("squash_valid_low", {31'h0, inst_valid}, 32'h0);
      if (since == 1) check("wait_mem_addr", {{(32-ADDR_W){1'b0}}, mem_addr},
                            {{(32-ADDR_W){1'b0}}, RESET_PC[ADDR_W+1:2]});
      if (since == 2) check("wait_valid_low", {31'h0, inst_valid}, 32'h0);
      if (since == 3 && !p_squash) check("first_valid", {31'h0, inst_valid}, 32'h1);
      if (p_stall) begin
        check("stall_valid", {31'h0, inst_valid}, 32'h1);
        check("stall_out", inst_out, p_out);
        check("stall_pc", inst_pc, p_pc);
      end
      if (!HALT_EN) check("halted_low", {31'h0, halted}, 32'h0);
      else if (halted) begin
        check("halt_expected", {31'h0, (exp_q.size() > 0 && exp_q[0].halt)}, 32'h1);
        check("halt_valid_low", {31'h0, inst_valid}, 32'h0);
        if (exp_q.size() > 0)
          check("halt_mem_addr", {{(32-ADDR_W){1'b0}}, mem_addr},
                {{(32-ADDR_W){1'b0}}, exp_q[0].pc[ADDR_W+1:2]});
      end
      squash = redirect_valid && since >= 2;
      if (inst_valid && inst_ready && !squash) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL xfer_unexpected: got pc %h word %h expected no transfer", inst_pc, inst_out);
        end else begin
          check("xfer_not_halt_word", {31'h0, exp_q[0].halt}, 32'h0);
          check("xfer_pc", inst_pc, exp_q[0].pc);
          check("xfer_word", inst_out, exp_q[0].word);
          void'(exp_q.pop_front());
        end
      end
      p_squash = squash;
      p_stall  = inst_valid && !inst_ready && !squash;
      p_out    = inst_out;
      p_pc     = inst_pc;
    end
  end

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 15) == 0) mem[i] = 32'h0;
    end
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;
    mem[511] = 32'hDEAD_BEEF;

    // Spec-style directed sequence
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h40);               // redirect in WAIT must be ignored
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0006);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_07FC);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h100);              // reset mid-stall with a redirect pending
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0: tgt = 32'h0000_07FC;
        1: tgt = 32'hFFFF_FFF8;
        2: tgt = {22'h0, $urandom_range(0, 1023)};
        default: tgt = $urandom;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, tgt);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    check("progress_xfers", {31'h0, n_xfer > 500}, 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
